// File: rtl/mac8_pkg.sv
`default_nettype none
// ============================================================================
// mac8_pkg : shared types and widths for the mac8 sequencer slice
// Rev 1.0
// ============================================================================
package mac8_pkg;

  localparam int OP_W  = 8;
  localparam int ACC_W = 32;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    RUN   = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_e;

endpackage
`default_nettype wire

// File: rtl/mac8_perf_cnt.sv
`default_nettype none
// ============================================================================
// mac8_perf_cnt : saturating event counter, cleared only by rst
// Rev 1.0
// ============================================================================
module mac8_perf_cnt #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != '1)) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule
`default_nettype wire

// File: rtl/mac8_seq_ctrl.sv
`default_nettype none
// ============================================================================
// mac8_seq_ctrl : command/operand/result sequencer for one mac8 MAC unit.
// Optional performance counters enabled by MAC8_SEQ_CTRL_PERF_EN.
// Rev 1.0
// ============================================================================
module mac8_seq_ctrl
  import mac8_pkg::*;
#(
  parameter int LEN_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [OP_W-1:0]  op_a,
  input  logic [OP_W-1:0]  op_b,
  output logic [OP_W-1:0]  mac_a,
  output logic [OP_W-1:0]  mac_b,
  output logic             mac_en,
  output logic             mac_clr,
  input  logic [ACC_W-1:0] mac_acc,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [ACC_W-1:0] res_data,
  output logic             busy,
  output logic [31:0]      perf_beats,
  output logic [31:0]      perf_stalls,
  output logic [31:0]      perf_jobs
);

  state_e           state_q, state_d;
  logic [LEN_W-1:0] remaining_q, remaining_d;
  logic [ACC_W-1:0] res_data_q, res_data_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      remaining_q <= '0;
      res_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      res_data_q  <= res_data_d;
    end
  end

  // MAC operands are forced to zero outside RUN so the MAC's bypass gate stays shut.
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    res_data_d  = res_data_q;
    cmd_ready   = 1'b0;
    op_ready    = 1'b0;
    mac_en      = 1'b0;
    mac_clr     = 1'b0;
    mac_a       = '0;
    mac_b       = '0;
    res_valid   = 1'b0;
    unique case (state_q)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          remaining_d = cmd_len;
          state_d     = CLEAR;
        end
      end
      CLEAR: begin
        mac_clr = 1'b1;
        state_d = (remaining_q != '0) ? RUN : DRAIN;
      end
      RUN: begin
        op_ready = 1'b1;
        mac_en   = op_valid;
        mac_a    = op_a;
        mac_b    = op_b;
        if (op_valid) begin
          remaining_d = remaining_q - LEN_W'(1);
          if (remaining_q == LEN_W'(1)) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        res_data_d = mac_acc;
        state_d    = DONE;
      end
      DONE: begin
        res_valid = 1'b1;
        if (res_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign busy     = (state_q != IDLE);
  assign res_data = res_data_q;

`ifdef MAC8_SEQ_CTRL_PERF_EN
  logic beat_inc;
  logic stall_inc;
  logic job_inc;

  assign beat_inc  = (state_q == RUN) && op_valid;
  assign stall_inc = (state_q == RUN) && !op_valid;
  assign job_inc   = (state_q == DONE) && res_ready;

  mac8_perf_cnt #(.WIDTH(32)) u_cnt_beats (
    .clk   (clk),
    .rst   (rst),
    .inc   (beat_inc),
    .count (perf_beats)
  );

  mac8_perf_cnt #(.WIDTH(32)) u_cnt_stalls (
    .clk   (clk),
    .rst   (rst),
    .inc   (stall_inc),
    .count (perf_stalls)
  );

  mac8_perf_cnt #(.WIDTH(32)) u_cnt_jobs (
    .clk   (clk),
    .rst   (rst),
    .inc   (job_inc),
    .count (perf_jobs)
  );
`else
  assign perf_beats  = '0;
  assign perf_stalls = '0;
  assign perf_jobs   = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mac8_seq_ctrl.sv
`default_nettype none
// ============================================================================
// tb_mac8_seq_ctrl : scoreboard bench for mac8_seq_ctrl with a behavioural MAC
// Rev 1.0
// ============================================================================
module tb_mac8_seq_ctrl;

  localparam int LEN_W = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [LEN_W-1:0] cmd_len = '0;
  logic             op_valid = 1'b0;
  logic             op_ready;
  logic [7:0]       op_a = '0;
  logic [7:0]       op_b = '0;
  logic [7:0]       mac_a, mac_b;
  logic             mac_en, mac_clr;
  logic [31:0]      mac_acc;
  logic             res_valid;
  logic             res_ready = 1'b0;
  logic [31:0]      res_data;
  logic             busy;
  logic [31:0]      perf_beats, perf_stalls, perf_jobs;

  mac8_seq_ctrl #(.LEN_W(LEN_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_len     (cmd_len),
    .op_valid    (op_valid),
    .op_ready    (op_ready),
    .op_a        (op_a),
    .op_b        (op_b),
    .mac_a       (mac_a),
    .mac_b       (mac_b),
    .mac_en      (mac_en),
    .mac_clr     (mac_clr),
    .mac_acc     (mac_acc),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_data    (res_data),
    .busy        (busy),
    .perf_beats  (perf_beats),
    .perf_stalls (perf_stalls),
    .perf_jobs   (perf_jobs)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Stand-in for the mac8 instance: one-cycle accumulate, untouched by rst,
  // starting from garbage so a missing clear shows up.
  function automatic logic [31:0] prodf(logic [7:0] x, logic [7:0] y);
    int xi, yi;
    xi = int'($signed(x));
    yi = int'($signed(y));
    return 32'(xi * yi);
  endfunction

  logic [31:0] acc_m = 32'h5A5A_5A5A;
  always @(posedge clk) begin
    if (mac_clr) acc_m <= '0;
    else if (mac_en) acc_m <= acc_m + prodf(mac_a, mac_b);
  end
  assign mac_acc = acc_m;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%08h) expected %0d (0x%08h) at cycle %0d",
               name, $signed(act), act, $signed(exp), exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    total++;
    bad++;
    $display("FAIL %s at cycle %0d", name, cyc);
  endtask

  // Scoreboard queues and reference counters
  int exp_q[$];
  int exp_cyc_q[$];
  int hold_q[$];
  int m_beats = 0, m_stalls = 0, m_jobs = 0;
  int clr_seen = 0, cmd_acc = 0;

  function automatic logic [31:0] pexp(input int v);
`ifdef MAC8_SEQ_CTRL_PERF_EN
    return 32'(v);
`else
    return (v == v) ? 32'd0 : 32'd1;
`endif
  endfunction

  // Monitor: protocol checks every cycle, result checks on res_valid
  bit          in_res = 0;
  int          wait_cnt = 0;
  int          hold_cur = 0;
  logic [31:0] held = '0;

  always @(negedge clk) begin
    if (rst) begin
      in_res    = 0;
      res_ready = 1'b0;
    end else begin
      if (mac_clr) clr_seen++;
      chk("mac_en_gate", 32'(mac_en), 32'(op_valid && op_ready));
      if (op_ready) begin
        chk("mac_a_pass", 32'(mac_a), 32'(op_a));
        chk("mac_b_pass", 32'(mac_b), 32'(op_b));
      end else begin
        chk("mac_a_idle", 32'(mac_a), 32'd0);
        chk("mac_b_idle", 32'(mac_b), 32'd0);
      end
      if (res_valid) begin
        if (!in_res) begin
          in_res   = 1;
          wait_cnt = 0;
          held     = res_data;
          if (exp_cyc_q.size() == 0 || hold_q.size() == 0) begin
            fail_now("unexpected_result");
            hold_cur = 0;
          end else begin
            chk("res_valid_cycle", 32'(cyc), 32'(exp_cyc_q.pop_front()));
            hold_cur = hold_q.pop_front();
          end
        end else begin
          chk("res_stable", res_data, held);
        end
        chk("cmd_ready_in_done", 32'(cmd_ready), 32'd0);
        if (wait_cnt >= hold_cur) begin
          res_ready = 1'b1;
          in_res    = 0;
          if (exp_q.size() == 0) fail_now("result_without_expectation");
          else chk("res_data", res_data, 32'(exp_q.pop_front()));
          m_jobs++;
        end else begin
          res_ready = 1'b0;
        end
        wait_cnt++;
      end else begin
        res_ready = 1'b0;
      end
    end
  end

  // Driver
  byte ja[$];
  byte jb[$];
  int  jg[$];
  bit  prev_fast = 0;
  int  prev_t = 0, prev_n = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle_reset(input string tag);
    chk({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_res_valid"}, 32'(res_valid), 32'd0);
    chk({tag, "_res_data"}, res_data, 32'd0);
    chk({tag, "_op_ready"}, 32'(op_ready), 32'd0);
    chk({tag, "_mac_clr"}, 32'(mac_clr), 32'd0);
    chk({tag, "_perf_beats"}, perf_beats, 32'd0);
    chk({tag, "_perf_stalls"}, perf_stalls, 32'd0);
    chk({tag, "_perf_jobs"}, perf_jobs, 32'd0);
  endtask

  task automatic check_perf();
    int w;
    w = 0;
    @(negedge clk);
    while (busy && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (busy) fail_now("idle_timeout");
    chk("perf_beats", perf_beats, pexp(m_beats));
    chk("perf_stalls", perf_stalls, pexp(m_stalls));
    chk("perf_jobs", perf_jobs, pexp(m_jobs));
    prev_fast = 0;
    @(posedge clk);
    #1;
  endtask

  // Issues one job from ja/jb/jg; abort_after >= 0 pulses rst before that beat.
  task automatic run_job(input int n, input int hold, input int abort_after);
    int t, w, sum, gsum;
    cmd_valid = 1'b1;
    cmd_len   = LEN_W'(n);
    w = 0;
    @(negedge clk);
    while (!cmd_ready && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (!cmd_ready) begin
      fail_now("cmd_accept_timeout");
      cmd_valid = 1'b0;
      @(posedge clk);
      #1;
      return;
    end
    t = cyc;
    if (prev_fast) chk("job_period", 32'(t - prev_t), 32'(prev_n + 4));
    cmd_acc++;
    tick();
    cmd_valid = 1'b0;
    if (n == 0) begin
      op_valid = 1'b1;
      op_a = 8'($urandom);
      op_b = 8'($urandom);
    end
    @(negedge clk);
    chk("mac_clr_pulse", 32'(mac_clr), 32'd1);
    tick();
    if (n == 0) begin
      exp_q.push_back(0);
      exp_cyc_q.push_back(t + 3);
      hold_q.push_back(hold);
      tick();
      op_valid = 1'b0;
      prev_fast = (hold == 0);
      prev_t = t;
      prev_n = 0;
      return;
    end
    sum  = 0;
    gsum = 0;
    for (int i = 0; i < n; i++) begin
      if (i == abort_after) begin
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        m_beats = 0;
        m_stalls = 0;
        m_jobs = 0;
        prev_fast = 0;
        @(negedge clk);
        check_idle_reset("abort");
        @(posedge clk);
        #1;
        return;
      end
      repeat (jg[i]) tick();
      op_valid = 1'b1;
      op_a = ja[i];
      op_b = jb[i];
      @(negedge clk);
      chk("op_ready_beat", 32'(op_ready), 32'd1);
      tick();
      op_valid = 1'b0;
      sum  += int'(ja[i]) * int'(jb[i]);
      gsum += jg[i];
      m_beats++;
      m_stalls += jg[i];
    end
    exp_q.push_back(sum);
    exp_cyc_q.push_back(t + 3 + n + gsum);
    hold_q.push_back(hold);
    prev_fast = (gsum == 0) && (hold == 0);
    prev_t = t;
    prev_n = n;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog_timeout at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    // Reset, then idle with stray op_valid
    @(posedge clk);
    @(negedge clk);
    check_idle_reset("reset");
    chk("reset_mac_en", 32'(mac_en), 32'd0);
    chk("reset_mac_a", 32'(mac_a), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    op_valid = 1'b1;
    op_a = 8'h55;
    op_b = 8'hAA;
    repeat (3) tick();
    op_valid = 1'b0;
    tick();

    // N=4 no stalls
    ja = '{3, -2, 127, -128};
    jb = '{4, 5, 127, -128};
    jg = '{0, 0, 0, 0};
    run_job(4, 0, -1);

    // N=3 gapped, slow consumer
    ja = '{-7, 100, -128};
    jb = '{9, -3, 127};
    jg = '{0, 2, 2};
    run_job(3, 5, -1);
    check_perf();

    // N=0 with op_valid held high
    run_job(0, 0, -1);

    // Back-to-back
    ja = '{10, 10};
    jb = '{10, 10};
    jg = '{0, 0};
    run_job(2, 0, -1);
    ja = '{-1};
    jb = '{1};
    jg = '{0};
    run_job(1, 0, -1);
    check_perf();

    // Abort after 2 of 5 beats, then N=1 (7,7)
    ja = '{50, 60, 70, 80, 90};
    jb = '{-50, 60, -70, 80, -90};
    jg = '{0, 1, 0, 0, 0};
    run_job(5, 0, 2);
    ja = '{7};
    jb = '{7};
    jg = '{0};
    run_job(1, 0, -1);
    check_perf();

    // Randomized jobs
    for (int j = 0; j < 20; j++) begin
      n = int'($urandom_range(0, 6));
      ja.delete();
      jb.delete();
      jg.delete();
      for (int k = 0; k < n; k++) begin
        ja.push_back(byte'($urandom));
        jb.push_back(byte'($urandom));
        jg.push_back(int'($urandom_range(0, 2)));
      end
      run_job(n, int'($urandom_range(0, 3)), -1);
    end
    check_perf();

    begin
      int w;
      w = 0;
      while (exp_q.size() != 0 && w < 200) begin
        tick();
        w++;
      end
      if (exp_q.size() != 0) fail_now("results_outstanding");
    end
    chk("clr_pulses", 32'(clr_seen), 32'(cmd_acc));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
